// File: rtl/lampfpu_log_postnorm.sv
// lampfpu_log_postnorm: post-normalization, rounding and output buffering for
// the bfloat16 log unit. Stage 1 normalizes the extended mantissa, stage 2
// rounds/saturates and packs, and a small FIFO presents results to the FPU
// result bus with a valid/ready handshake.
// Optional feature macro: LAMPFPU_LOG_RNE_EN (defined: round-to-nearest-even,
// undefined: truncation).
module lampfpu_log_postnorm #(
    parameter int OUT_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        s_i,
    input  logic [7:0]  e_i,
    input  logic [11:0] f_i,
    input  logic        isToRound_i,
    output logic        busy_o,
    output logic [15:0] result_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic        inexact_o,
    output logic        drop_o
);
    localparam int E_DW  = 8;
    localparam int F_DW  = 7;
    localparam int S_DW  = 1;
    localparam int RES_W = S_DW + E_DW + F_DW;
    localparam int ENT_W = RES_W + 3;
    localparam int AW    = $clog2(OUT_DEPTH);
    localparam int OCC_W = AW + 2;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(OUT_DEPTH);
    localparam logic signed [9:0] EXP_MAX  = 10'sd255;

    typedef enum logic [1:0] {K_NORM, K_ZERO, K_UFLOW, K_SPEC} kind_e;

    // Leading-zero count of the 11-bit {hidden, fraction, G, R, S} field.
    function automatic logic [3:0] lzc(input logic [10:0] m);
        lzc = 4'd11;
        for (int i = 0; i <= 10; i++) begin
            if (m[i]) lzc = 4'(10 - i);
        end
    endfunction

`ifdef LAMPFPU_LOG_RNE_EN
    // Round-to-nearest-even decision from {LSB, G, R, S}.
    function automatic logic rne_up(input logic [3:0] lgrs);
        rne_up = lgrs[2] & (lgrs[1] | lgrs[0] | lgrs[3]);
    endfunction
`endif

    // Saturate to signed Inf when the exponent leaves the finite range; MSB = overflow.
    function automatic logic [RES_W:0] sat_pack(input logic sgn, input logic signed [9:0] ex,
                                                 input logic [F_DW-1:0] fr);
        if (ex >= EXP_MAX) sat_pack = {1'b1, sgn, 8'hFF, 7'h00};
        else               sat_pack = {1'b0, sgn, ex[E_DW-1:0], fr};
    endfunction

    logic              s1_vld_d, s1_vld_q;
    logic              s1_sgn_d, s1_sgn_q;
    logic signed [9:0] s1_exp_d, s1_exp_q;
    logic [9:0]        s1_man_d, s1_man_q;
    kind_e             s1_kind_d, s1_kind_q;
    logic              s2_vld_d, s2_vld_q;
    logic [ENT_W-1:0]  s2_ent_d, s2_ent_q;
    logic [ENT_W-1:0]  mem_q [OUT_DEPTH];
    logic [AW-1:0]     wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [AW:0]       cnt_d, cnt_q;
    logic              drop_d, drop_q;
    logic [OCC_W-1:0]  occ;
    logic              full, push, pop;
    logic signed [9:0] exp_in;
    logic [3:0]        lz;

    assign occ    = OCC_W'(cnt_q) + OCC_W'(s1_vld_q) + OCC_W'(s2_vld_q);
    assign full   = (occ >= DEPTH_OCC);
    assign busy_o = full;
    assign valid_o = (cnt_q != '0);
    assign pop    = valid_o & ready_i;
    assign push   = s2_vld_q;
    assign drop_o = drop_q;
    assign {result_o, overflow_o, underflow_o, inexact_o} = mem_q[rd_ptr_q];

    // Stage 1 next state: normalize carry / leading zeros, classify zero, underflow, special.
    always_comb begin
        s1_vld_d  = valid_i & (~full | pop);
        s1_sgn_d  = s_i;
        exp_in    = $signed({2'b00, e_i});
        s1_exp_d  = exp_in;
        s1_man_d  = f_i[9:0];
        s1_kind_d = K_NORM;
        lz        = lzc(f_i[10:0]);
        drop_d    = drop_q | (valid_i & full & ~pop);
        if (!isToRound_i) begin
            s1_kind_d = K_SPEC;
        end else if (f_i[11]) begin
            // Carry set: shift right one, the shifted-out bit folds into sticky.
            s1_man_d = {f_i[10:2], f_i[1] | f_i[0]};
            s1_exp_d = exp_in + 10'sd1;
        end else if (f_i[10:0] == 11'd0) begin
            s1_kind_d = K_ZERO;
        end else if (!f_i[10]) begin
            // Bit 10 is zero here, so shifting only the low 10 bits is exact.
            s1_man_d = f_i[9:0] << lz;
            s1_exp_d = exp_in - $signed({6'b000000, lz});
            if (s1_exp_d <= 10'sd0) s1_kind_d = K_UFLOW;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s1_sgn_q  <= 1'b0;
            s1_exp_q  <= '0;
            s1_man_q  <= '0;
            s1_kind_q <= K_NORM;
            drop_q    <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_sgn_q  <= s1_sgn_d;
            s1_exp_q  <= s1_exp_d;
            s1_man_q  <= s1_man_d;
            s1_kind_q <= s1_kind_d;
            drop_q    <= drop_d;
        end
    end

    // Stage 2 next state: round, propagate rounding carry, saturate and pack with flags.
    always_comb begin
        logic              rnd;
        logic [7:0]        frac_r;
        logic signed [9:0] exp_r;
        logic [RES_W:0]    packed_w;
`ifdef LAMPFPU_LOG_RNE_EN
        rnd = rne_up(s1_man_q[3:0]);
`else
        rnd = 1'b0;
`endif
        frac_r   = {1'b0, s1_man_q[9:3]} + {7'd0, rnd};
        exp_r    = s1_exp_q + (frac_r[7] ? 10'sd1 : 10'sd0);
        packed_w = sat_pack(s1_sgn_q, exp_r, frac_r[6:0]);
        s2_vld_d = s1_vld_q;
        case (s1_kind_q)
            K_SPEC:  s2_ent_d = {s1_sgn_q, s1_exp_q[7:0], s1_man_q[9:3], 3'b000};
            K_ZERO:  s2_ent_d = {s1_sgn_q, 15'd0, 3'b000};
            K_UFLOW: s2_ent_d = {s1_sgn_q, 15'd0, 3'b011};
            default: s2_ent_d = {packed_w[RES_W-1:0], packed_w[RES_W], 1'b0,
                                 packed_w[RES_W] | (|s1_man_q[2:0])};
        endcase
    end

    // Stage 2 registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vld_q <= 1'b0;
            s2_ent_q <= '0;
        end else begin
            s2_vld_q <= s2_vld_d;
            s2_ent_q <= s2_ent_d;
        end
    end

    // FIFO pointer/count next state; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
        else if (!push && pop) cnt_d = cnt_q - (AW+1)'(1);
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= s2_ent_q;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_lampfpu_log_postnorm.sv
// Testbench for lampfpu_log_postnorm (OUT_DEPTH=2); expected words come from
// hand-computed constants, with the rounding cases selected by LAMPFPU_LOG_RNE_EN.
module tb_lampfpu_log_postnorm;
    logic        clk = 1'b0;
    logic        rst, valid_i, s_i, isToRound_i, ready_i;
    logic [7:0]  e_i;
    logic [11:0] f_i;
    logic        busy_o, valid_o, overflow_o, underflow_o, inexact_o, drop_o;
    logic [15:0] result_o;

    int total = 0;
    int bad   = 0;
    logic [18:0] sb[$];

    lampfpu_log_postnorm #(.OUT_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .s_i(s_i), .e_i(e_i), .f_i(f_i),
        .isToRound_i(isToRound_i), .busy_o(busy_o), .result_o(result_o),
        .valid_o(valid_o), .ready_i(ready_i), .overflow_o(overflow_o),
        .underflow_o(underflow_o), .inexact_o(inexact_o), .drop_o(drop_o)
    );

    always #5 clk = ~clk;

`ifdef LAMPFPU_LOG_RNE_EN
    localparam logic [18:0] EXP_TIE   = {16'h3F82, 3'b001};
    localparam logic [18:0] EXP_CARRY = {16'h4000, 3'b001};
`else
    localparam logic [18:0] EXP_TIE   = {16'h3F81, 3'b001};
    localparam logic [18:0] EXP_CARRY = {16'h3FFF, 3'b001};
`endif

    // Drive one valid_i pulse; optionally record its expected output word.
    task automatic issue(input logic s, input logic [7:0] e, input logic [11:0] f,
                         input logic isr, input logic [18:0] expv, input bit track);
        @(negedge clk);
        s_i = s; e_i = e; f_i = f; isToRound_i = isr; valid_i = 1'b1;
        if (track) sb.push_back(expv);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    // Wait (bounded) for valid_o, capture the head, pop the scoreboard, consume it.
    task automatic collect(output bit ok, output logic [18:0] obs, output logic [18:0] expv);
        int n = 0;
        while (!valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok   = valid_o;
        obs  = {result_o, overflow_o, underflow_o, inexact_o};
        expv = 19'h0;
        if (sb.size() > 0) expv = sb.pop_front();
        if (ok) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [21:0] o;
        rst = 1'b0; valid_i = 1'b0; ready_i = 1'b0; s_i = 1'b0; e_i = 8'd0; f_i = 12'd0;
        isToRound_i = 1'b0;
        repeat (3) @(negedge clk);
        o = {result_o, valid_o, busy_o, overflow_o, underflow_o, inexact_o, drop_o};
        total++;
        if (o !== 22'h0) begin bad++; $display("FAIL reset_held: got %h want %h", o, 22'h0); end
        rst = 1'b1;
        @(negedge clk);
        o = {result_o, valid_o, busy_o, overflow_o, underflow_o, inexact_o, drop_o};
        total++;
        if (o !== 22'h0) begin bad++; $display("FAIL reset_released: got %h want %h", o, 22'h0); end
    endtask

    task automatic test_exact;
        logic [18:0] obs, expv;
        ready_i = 1'b1;
        @(negedge clk);
        s_i = 1'b0; e_i = 8'd127; f_i = 12'b0_1_0000000_000; isToRound_i = 1'b1; valid_i = 1'b1;
        sb.push_back({16'h3F80, 3'b000});
        @(negedge clk);
        valid_i = 1'b0;
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL latency_n1: got %b want 0", valid_o); end
        @(negedge clk);
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL latency_n2: got %b want 0", valid_o); end
        @(negedge clk);
        obs  = {result_o, overflow_o, underflow_o, inexact_o};
        expv = sb.pop_front();
        total++;
        if (valid_o !== 1'b1 || obs !== expv) begin
            bad++; $display("FAIL exact: got v=%b %h want v=1 %h", valid_o, obs, expv);
        end
        @(negedge clk);
    endtask

    task automatic test_rounding;
        bit ok; logic [18:0] obs, expv;
        issue(1'b0, 8'd127, 12'b0_1_0000001_100, 1'b1, EXP_TIE, 1'b1);
        collect(ok, obs, expv);
        total++;
        if (!ok || obs !== expv) begin bad++; $display("FAIL tie: got ok=%b %h want %h", ok, obs, expv); end
        issue(1'b0, 8'd127, 12'b0_1_1111111_110, 1'b1, EXP_CARRY, 1'b1);
        collect(ok, obs, expv);
        total++;
        if (!ok || obs !== expv) begin bad++; $display("FAIL carry: got ok=%b %h want %h", ok, obs, expv); end
    endtask

    task automatic test_ovf_special;
        bit ok; logic [18:0] obs, expv;
        issue(1'b0, 8'd254, 12'b1_1_1111111_000, 1'b1, {16'h7F80, 3'b101}, 1'b1);
        collect(ok, obs, expv);
        total++;
        if (!ok || obs !== expv) begin bad++; $display("FAIL overflow: got ok=%b %h want %h", ok, obs, expv); end
        issue(1'b0, 8'hFF, 12'b0_1_1000000_000, 1'b0, {16'h7FC0, 3'b000}, 1'b1);
        collect(ok, obs, expv);
        total++;
        if (!ok || obs !== expv) begin bad++; $display("FAIL special: got ok=%b %h want %h", ok, obs, expv); end
    endtask

    task automatic test_underflow;
        bit ok; logic [18:0] obs, expv;
        issue(1'b0, 8'd3, 12'b0_0_0000100_000, 1'b1, {16'h0000, 3'b011}, 1'b1);
        collect(ok, obs, expv);
        total++;
        if (!ok || obs !== expv) begin bad++; $display("FAIL underflow: got ok=%b %h want %h", ok, obs, expv); end
    endtask

    task automatic test_back_to_back;
        logic        bs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0]  be[4] = '{8'd130, 8'd100, 8'd50, 8'd127};
        logic [11:0] bf[4] = '{12'b0_0_1000000_000, 12'b1_0_0000000_011, 12'd0, 12'b0_1_0000000_000};
        logic [18:0] bx[4] = '{{16'h4080, 3'b000}, {16'h3280, 3'b001},
                               {16'h8000, 3'b000}, {16'hBF80, 3'b000}};
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    issue(bs[i], be[i], bf[i], 1'b1, bx[i], 1'b1);
                    @(negedge clk);
                end
            end
            begin
                bit ok; logic [18:0] obs, expv;
                for (int j = 0; j < 4; j++) begin
                    collect(ok, obs, expv);
                    total++;
                    if (!ok || obs !== expv) begin
                        bad++; $display("FAIL b2b_%0d: got ok=%b %h want %h", j, ok, obs, expv);
                    end
                end
            end
        join
    endtask

    task automatic test_backpressure;
        logic [18:0] obs, expv;
        logic [21:0] o;
        ready_i = 1'b0;
        issue(1'b0, 8'd127, 12'b0_1_0000000_000, 1'b1, {16'h3F80, 3'b000}, 1'b1);
        @(negedge clk);
        issue(1'b0, 8'd128, 12'b0_1_0000000_000, 1'b1, {16'h4000, 3'b000}, 1'b1);
        repeat (3) @(negedge clk);
        obs = {result_o, overflow_o, underflow_o, inexact_o};
        total++;
        if ({busy_o, valid_o} !== 2'b11 || obs !== sb[0]) begin
            bad++; $display("FAIL bp_full: got busy=%b v=%b %h want 1 1 %h", busy_o, valid_o, obs, sb[0]);
        end
        repeat (2) @(negedge clk);
        obs = {result_o, overflow_o, underflow_o, inexact_o};
        total++;
        if (valid_o !== 1'b1 || obs !== sb[0]) begin
            bad++; $display("FAIL bp_stable: got v=%b %h want 1 %h", valid_o, obs, sb[0]);
        end
        issue(1'b1, 8'd10, 12'b0_1_0000000_000, 1'b1, 19'h0, 1'b0);
        total++;
        if (drop_o !== 1'b1) begin bad++; $display("FAIL bp_drop: got %b want 1", drop_o); end
        repeat (2) @(negedge clk);
        obs = {result_o, overflow_o, underflow_o, inexact_o};
        total++;
        if ({busy_o, valid_o} !== 2'b11 || obs !== sb[0]) begin
            bad++; $display("FAIL bp_after_drop: got busy=%b v=%b %h want 1 1 %h", busy_o, valid_o, obs, sb[0]);
        end
        ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            obs  = {result_o, overflow_o, underflow_o, inexact_o};
            expv = (sb.size() > 0) ? sb[0] : 19'h0;
            if (sb.size() > 0) void'(sb.pop_front());
            total++;
            if (valid_o !== 1'b1 || obs !== expv) begin
                bad++; $display("FAIL bp_drain_%0d: got v=%b %h want 1 %h", k, valid_o, obs, expv);
            end
            @(negedge clk);
        end
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", valid_o); end
        rst = 1'b0;
        #1;
        o = {result_o, valid_o, busy_o, overflow_o, underflow_o, inexact_o, drop_o};
        total++;
        if (o !== 22'h0) begin bad++; $display("FAIL bp_reset: got %h want %h", o, 22'h0); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset_mid;
        ready_i = 1'b1;
        issue(1'b0, 8'd127, 12'b0_1_0000000_000, 1'b1, 19'h0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ({valid_o, busy_o, drop_o} !== 3'b000) begin
            bad++; $display("FAIL reset_mid: got v/busy/drop=%b want 000", {valid_o, busy_o, drop_o});
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_rounding();
        test_ovf_special();
        test_underflow();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
